// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: default counter width and per-boundary payload layouts.
// Stage registers carry these as opaque DATA_W-bit vectors ($bits(<type>_t)).
package pipe_pkg;

  localparam int STALL_CNT_W_DEF = 16;
  localparam int XLEN            = 32;
  localparam int REG_AW          = 5;
  localparam int INSTR_ID_W      = 8;

  typedef struct packed {
    logic [XLEN-1:0]       pc;
    logic [XLEN-1:0]       instr;
    logic [INSTR_ID_W-1:0] instr_id;
  } if_id_payload_t;

  typedef struct packed {
    logic [REG_AW-1:0]     rs1_addr;
    logic [REG_AW-1:0]     rs2_addr;
    logic [REG_AW-1:0]     rd_addr;
    logic [XLEN-1:0]       rs1_val;
    logic [XLEN-1:0]       rs2_val;
    logic [XLEN-1:0]       pc;
    logic [XLEN-1:0]       imm;
    logic [INSTR_ID_W-1:0] instr_id;
    logic                  rd_valid;
  } id_ex_payload_t;

  typedef struct packed {
    logic [REG_AW-1:0]     rs1_addr;
    logic [REG_AW-1:0]     rs2_addr;
    logic [REG_AW-1:0]     rd_addr;
    logic [XLEN-1:0]       rs1_val;
    logic [XLEN-1:0]       rs2_val;
    logic [XLEN-1:0]       pc;
    logic [XLEN-1:0]       mem_addr;
    logic [XLEN-1:0]       exec_output;
    logic                  jump;
    logic [XLEN-1:0]       jump_addr;
    logic [INSTR_ID_W-1:0] instr_id;
    logic                  rd_valid;
  } ex_mem_payload_t;

  typedef struct packed {
    logic [REG_AW-1:0]     rd_addr;
    logic [XLEN-1:0]       wb_data;
    logic [INSTR_ID_W-1:0] instr_id;
    logic                  rd_valid;
  } mem_wb_payload_t;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
// Reusable for performance counters; never wraps.
module pipe_sat_counter
  import pipe_pkg::*;
#(
  parameter int CNT_W = STALL_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_next_s;

  // next count: clear, saturating increment, or hold
  always_comb begin
    cnt_next_s = cnt_r;
    if (clr) begin
      cnt_next_s = '0;
    end else if (inc && (cnt_r != CNT_MAX)) begin
      cnt_next_s = cnt_r + CNT_ONE;
    end else begin
      cnt_next_s = cnt_r;
    end
  end

  // count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_next_s;
    end
  end

  assign cnt = cnt_r;

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised valid/ready pipeline stage register with flush and stall counter.
// Define PIPE_STAGE_SKID_EN for a 2-entry skid buffer with a registered in_ready.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int CNT_W          = STALL_CNT_W_DEF,
  parameter int CLEAR_ON_FLUSH = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  input  logic              stall_cnt_clr,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              out_valid_r;
  logic [DATA_W-1:0] out_data_r;
  logic              valid_next_s;
  logic [DATA_W-1:0] data_next_s;
  logic              in_xfer_s;
  logic              out_xfer_s;
  logic              stall_s;
  logic [DATA_W-1:0] flush_data_s;

  assign in_xfer_s    = in_valid & in_ready;
  assign out_xfer_s   = out_valid_r & out_ready;
  assign flush_data_s = (CLEAR_ON_FLUSH != 0) ? '0 : out_data_r;

`ifdef PIPE_STAGE_SKID_EN
  logic              skid_valid_r;
  logic [DATA_W-1:0] skid_data_r;
  logic              skid_valid_next_s;
  logic [DATA_W-1:0] skid_data_next_s;

  // skid full is the only reason to refuse, so in_ready never sees out_ready
  assign in_ready = ~skid_valid_r;

  // next state of the output and skid entries (skid only fills while stalled)
  always_comb begin
    valid_next_s      = out_valid_r;
    data_next_s       = out_data_r;
    skid_valid_next_s = skid_valid_r;
    skid_data_next_s  = skid_data_r;
    if (flush) begin
      valid_next_s      = 1'b0;
      data_next_s       = flush_data_s;
      skid_valid_next_s = 1'b0;
      skid_data_next_s  = (CLEAR_ON_FLUSH != 0) ? '0 : skid_data_r;
    end else if (!out_valid_r) begin
      if (in_xfer_s) begin
        valid_next_s = 1'b1;
        data_next_s  = in_data;
      end else begin
        valid_next_s = 1'b0;
      end
    end else if (out_xfer_s) begin
      if (skid_valid_r) begin
        data_next_s       = skid_data_r;
        skid_valid_next_s = 1'b0;
      end else if (in_xfer_s) begin
        data_next_s = in_data;
      end else begin
        valid_next_s = 1'b0;
      end
    end else if (in_xfer_s) begin
      skid_valid_next_s = 1'b1;
      skid_data_next_s  = in_data;
    end else begin
      skid_valid_next_s = skid_valid_r;
    end
  end

  // skid entry registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_valid_r <= 1'b0;
      skid_data_r  <= '0;
    end else begin
      skid_valid_r <= skid_valid_next_s;
      skid_data_r  <= skid_data_next_s;
    end
  end
`else
  assign in_ready = ~out_valid_r | out_ready;

  // next state of the single output entry; a new payload wins over a drain
  always_comb begin
    valid_next_s = out_valid_r;
    data_next_s  = out_data_r;
    if (flush) begin
      valid_next_s = 1'b0;
      data_next_s  = flush_data_s;
    end else if (in_xfer_s) begin
      valid_next_s = 1'b1;
      data_next_s  = in_data;
    end else if (out_xfer_s) begin
      valid_next_s = 1'b0;
    end else begin
      valid_next_s = out_valid_r;
    end
  end
`endif

  // output entry registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
    end else begin
      out_valid_r <= valid_next_s;
      out_data_r  <= data_next_s;
    end
  end

  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;

  // a flushed cycle is not counted as a stall
  assign stall_s = out_valid_r & ~out_ready & ~flush;

  pipe_sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (stall_s),
    .clr (stall_cnt_clr),
    .cnt (stall_cnt)
  );

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Generic, parametrised pipeline stage register. It is the successor to the fixed-field stage registers between IF/ID/EX/MEM/WB.
- Carries an opaque payload of DATA_W bits with a valid/ready handshake in place of a bare enable. Adds a synchronous flush and a saturating back-pressure counter.
- Instantiated once per stage boundary in the core. Stage-specific fields are packed into the payload by the surrounding stage.

Parameters:
- DATA_W, 32, payload width in bits (≥1).
- CNT_W, 16, width of the stall-cycle counter (≥2).
- CLEAR_ON_FLUSH, 0, 1 = zero the payload registers on flush/reset-like drop; 0 = payload holds its stale value and only valid is cleared.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream offers a payload.
- in_ready  out  1  stage can accept this cycle.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  stage holds a valid payload.
- out_ready  in  1  downstream accepts this cycle.
- out_data  out  DATA_W  registered payload.
- flush  in  1  synchronous kill of everything held in the stage.
- stall_cnt_clr  in  1  synchronous clear of stall_cnt.
- stall_cnt  out  CNT_W  cycles spent with out_valid=1 and out_ready=0, saturating.

Behaviour:
- Reset (async, rst=1):
  - out_valid=0, out_data=0, stall_cnt=0, internal skid state empty.
  - in_ready follows its combinational definition from the reset state.
- Transfers:
  - in_xfer = in_valid & in_ready.
  - out_xfer = out_valid & out_ready.
  - Latency is 1 cycle from in_xfer to out_valid in the base build.
- Base build (macro undefined):
  - in_ready = ~out_valid | out_ready. This is combinational, with a ready pass-through path.
  - On in_xfer: out_data <= in_data, out_valid <= 1.
  - Else on out_xfer: out_valid <= 0, out_data held.
  - Otherwise all registers hold.
  - Simultaneous in_xfer and out_xfer: the new payload replaces the old one; out_valid stays 1 (full throughput).
- Flush (highest priority after rst):
  - On a cycle with flush=1, the next state has out_valid=0 and the skid entry empty.
  - Any in_xfer in that cycle is accepted from the upstream point of view but discarded.
  - out_data <= 0 if CLEAR_ON_FLUSH=1, else held.
  - in_ready is not gated by flush.
- out_valid never depends combinationally on in_valid.
- out_data must be stable while out_valid=1 and out_ready=0.
- stall_cnt:
  - Priority: stall_cnt_clr > increment.
  - Increments by 1 on each cycle with out_valid=1 & out_ready=0 & flush=0.
  - Saturates at 2^CNT_W−1 and does not wrap.
  - When stall_cnt_clr and a stall condition occur together, the result is 0.
- Reset asserted mid-transfer: the payload is lost and out_valid drops immediately (async).

Optional Feature:
- Macro: PIPE_STAGE_SKID_EN.
- When defined, the stage becomes a 2-entry skid buffer with no combinational path from out_ready to in_ready.
  - in_ready is a register: in_ready = ~skid_valid.
  - If in_xfer occurs while out_valid=1 and out_ready=0, the payload goes to skid_data and skid_valid <= 1.
  - On the next out_xfer, out_data <= skid_data and skid_valid <= 0, with out_valid remaining 1.
  - Ordering is strictly FIFO.
  - Flush clears both entries.
  - Latency stays 1 cycle when unstalled.
  - Reset value of skid_valid is 0.
- When undefined, the base behaviour above applies and no skid registers exist.

Decomposition:
- Shared package pipe_pkg holds:
  - localparam STALL_CNT_W_DEF=16.
  - Packed payload typedefs per boundary, e.g. ex_mem_payload_t with rs1/rs2/rd addresses, rs1/rs2 values, pc, mem_addr, exec_output, jump, jump_addr, instr_id, rd_valid.
- Optional sub-module: pipe_sat_counter (CNT_W, inc, clr → cnt, saturating). It is reusable for other performance counters.
- The handshake/skid datapath stays inline.

Test Plan:
1. Reset and single transfer: rst pulse, then in_valid=1, in_data=0xDEADBEEF, out_ready=1. Required response: out_valid=1 with out_data=0xDEADBEEF exactly one cycle later, and out_valid=0 the following cycle once in_valid=0.
2. Back-pressure: load 0x11, hold out_ready=0 for 5 cycles while in_valid=1, in_data=0x22.
   - Base build: in_ready=0, out_data stays 0x11, stall_cnt=5.
   - Skid build: 0x22 goes to skid, then in_ready=0; after release the outputs are 0x11 then 0x22 on consecutive cycles.
3. Streaming: in_valid=out_ready=1 with data 1,2,3,…,8 on consecutive cycles. Required response: out_data 1..8 on consecutive cycles, no bubbles, stall_cnt=0.
4. Flush with simultaneous input: stage holds 0x33 (stalled) and a flush is asserted together with in_valid=1, in_data=0x44. Required response: next cycle out_valid=0, 0x44 never appears, and out_data=0 only when CLEAR_ON_FLUSH=1.
5. Counter saturation and clear: CNT_W=2, stall for 6 cycles. Required response: stall_cnt reaches 3 and holds. Then stall_cnt_clr together with a stall cycle gives stall_cnt=0.
6. Async reset mid-stall: assert rst between clock edges while out_valid=1 and skid full. Required response: out_valid=0, skid empty and stall_cnt=0 immediately, before the next edge.
